// File: rtl/sli_pattern_gen_if.sv
// Video bus for sli_pattern_gen: pixel word plus timing strobes.
// The master drives the bus, the slave samples it.
interface sli_pattern_gen_if #(
  parameter int NCH    = 3,
  parameter int DATA_W = 8
);
  logic [NCH-1:0][DATA_W-1:0] pix;
  logic                       hsync;
  logic                       vsync;
  logic                       blank;

  modport master (output pix, hsync, vsync, blank);
  modport slave  (input  pix, hsync, vsync, blank);
endinterface

// File: rtl/sli_pattern_gen.sv
// Structured-light fringe generator for the HDMI pixel path.
// Replaces active video with a per-line LUT value, steps phase per frame and
// spatial frequency per phase set, and fires a fixed-width camera trigger.
// Optional: SLI_TL_DETECT_EN enables top-left change detection in
// pass-through mode (a changed top-left channel-0 value queues a trigger).
module sli_pattern_gen #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 720,
  parameter int N_FRAMES    = 8,
  parameter int N_FREQ      = 3,
  parameter int NCH         = 3,
  parameter int TRIG_CYCLES = 524288,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FRA_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
  localparam int FRQ_W = (N_FREQ > 1) ? $clog2(N_FREQ) : 1,
  localparam int CNT_W = $clog2(TRIG_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 lut_we,
  input  logic [AW-1:0]        lut_addr,
  input  logic [DATA_W-1:0]    lut_data,
  input  logic                 mode,
  input  logic [NCH-1:0]       ch_mask,
  input  logic                 rdy,
  sli_pattern_gen_if.slave     vin,
  sli_pattern_gen_if.master    vout,
  output logic                 trig,
  output logic [FRA_W-1:0]     fra,
  output logic [FRQ_W-1:0]     frq,
  output logic                 f_frm
);

  localparam int PSTEP = DEPTH / N_FRAMES;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] PSTEP_L = (AW+1)'(PSTEP);

  typedef logic [NCH-1:0][DATA_W-1:0] pix_t;

  pix_t             pix_r, pix_q;
  logic             hs_r, vs_r, bl_r, hs_q, vs_q, bl_q;
  logic             mode_r, rdy_r;
  logic [NCH-1:0]   mask_r;
  logic [DATA_W-1:0] lut [DEPTH];

  logic [AW-1:0]    sp, sp_n, acc, acc_n, step, sp_add, acc_add;
  logic [AW:0]      sp_sum, acc_sum;
  logic [FRA_W-1:0] fra_n;
  logic [FRQ_W-1:0] frq_n;
  logic             pend, pend_n, start, tl_hit;
  logic [CNT_W-1:0] cnt;
  logic             vs_rise, bl_rise;

  // Input register stage; controls travel with the pixel they qualify
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_r <= '0; hs_r <= 1'b0; vs_r <= 1'b0; bl_r <= 1'b1;
      mode_r <= 1'b0; rdy_r <= 1'b0; mask_r <= '0;
    end else begin
      pix_r <= vin.pix; hs_r <= vin.hsync; vs_r <= vin.vsync; bl_r <= vin.blank;
      mode_r <= mode; rdy_r <= rdy; mask_r <= ch_mask;
    end
  end

  // Output timing stage; doubles as the previous-value copy for edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_q <= 1'b0; vs_q <= 1'b0; bl_q <= 1'b1;
    end else begin
      hs_q <= hs_r; vs_q <= vs_r; bl_q <= bl_r;
    end
  end

  assign vs_rise = vs_r & ~vs_q;
  assign bl_rise = bl_r & ~bl_q;

  // LUT write port; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (lut_we && ({1'b0, lut_addr} < DEPTH_L)) lut[lut_addr] <= lut_data;
  end

  // Per-channel output mux: LUT value on masked channels in active pattern video
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                              pix_q[c] <= '0;
      else if (!mode_r && mask_r[c] && !bl_r) pix_q[c] <= lut[acc];
      else                                    pix_q[c] <= pix_r[c];
    end
  end

  assign vout.pix   = pix_q;
  assign vout.hsync = hs_q;
  assign vout.vsync = vs_q;
  assign vout.blank = bl_q;

`ifdef SLI_TL_DETECT_EN
  logic [DATA_W-1:0] tl_val;
  logic              tl_arm, bl_fall;

  assign bl_fall = ~bl_r & bl_q;
  assign tl_hit  = bl_fall & tl_arm & mode_r & (pix_r[0] != tl_val);

  // Arm at frame start, sample channel 0 at the first active pixel only
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tl_val <= '0; tl_arm <= 1'b0;
    end else begin
      if (vs_rise)      tl_arm <= 1'b1;
      else if (bl_fall) tl_arm <= 1'b0;
      if (tl_hit)       tl_val <= pix_r[0];
    end
  end
`else
  assign tl_hit = 1'b0;
`endif

  // Modular adders; both operands are below DEPTH so one subtract suffices
  assign step    = AW'(1) << frq;
  assign sp_sum  = {1'b0, sp} + PSTEP_L;
  assign sp_add  = AW'((sp_sum >= DEPTH_L) ? sp_sum - DEPTH_L : sp_sum);
  assign acc_sum = {1'b0, acc} + {1'b0, step};
  assign acc_add = AW'((acc_sum >= DEPTH_L) ? acc_sum - DEPTH_L : acc_sum);

  // Frame/line phase next-state: trigger release, advance, then acc reload
  always_comb begin
    fra_n  = fra;
    frq_n  = frq;
    sp_n   = sp;
    acc_n  = acc;
    pend_n = pend;
    start  = 1'b0;
    if (vs_rise) begin
      start  = pend;
      pend_n = 1'b0;
      if (rdy_r) begin
        if (fra == FRA_W'(N_FRAMES-1)) begin
          fra_n = '0;
          sp_n  = '0;
          frq_n = (frq == FRQ_W'(N_FREQ-1)) ? '0 : frq + FRQ_W'(1);
        end else begin
          fra_n = fra + FRA_W'(1);
          sp_n  = sp_add;
        end
        if (!mode_r) pend_n = 1'b1;
      end
      acc_n = sp_n;
    end else if (bl_rise) begin
      acc_n = acc_add;
    end
    if (tl_hit) pend_n = 1'b1;
  end

  // Phase state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fra <= '0; frq <= '0; sp <= '0; acc <= '0; pend <= 1'b0;
    end else begin
      fra <= fra_n; frq <= frq_n; sp <= sp_n; acc <= acc_n; pend <= pend_n;
    end
  end

  // Trigger pulse: reload on start (retrigger extends), high until cnt hits 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0; trig <= 1'b0;
    end else if (start) begin
      cnt <= CNT_W'(TRIG_CYCLES); trig <= 1'b1;
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      trig <= (cnt != CNT_W'(1));
    end
  end

  assign f_frm = (fra == '0);

endmodule

// File: tb/tb_sli_pattern_gen.sv
// Self-checking bench for sli_pattern_gen: event-level model of frame/line
// phase and trigger, compared every cycle, plus literal pins on key values.
module tb_sli_pattern_gen;
  localparam int DW = 8, DEPTH = 720, NF = 8, NQ = 3, NCH = 3, TC = 16;
  localparam int PSTEP = DEPTH / NF;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic           lut_we = 1'b0;
  logic [9:0]     lut_addr = '0;
  logic [7:0]     lut_data = '0;
  logic           mode = 1'b0, rdy = 1'b0;
  logic [2:0]     ch_mask = '0;
  logic           trig, f_frm;
  logic [2:0]     fra;
  logic [1:0]     frq;

  sli_pattern_gen_if #(.NCH(NCH), .DATA_W(DW)) vin ();
  sli_pattern_gen_if #(.NCH(NCH), .DATA_W(DW)) vout ();

  sli_pattern_gen #(.DATA_W(DW), .DEPTH(DEPTH), .N_FRAMES(NF), .N_FREQ(NQ),
                    .NCH(NCH), .TRIG_CYCLES(TC)) dut (
    .clk(clk), .rstn(rstn), .lut_we(lut_we), .lut_addr(lut_addr),
    .lut_data(lut_data), .mode(mode), .ch_mask(ch_mask), .rdy(rdy),
    .vin(vin), .vout(vout), .trig(trig), .fra(fra), .frq(frq), .f_frm(f_frm));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit          v;
    logic [23:0] pix;
    logic        hs, vs, bl;
    int          fra, frq;
    bit          ts;
  } exp_t;

  exp_t        cur, e1, e2;
  int          adv, line_m;
  bit          pend_m, prev_vs, prev_bl, tl_arm_m;
  logic [7:0]  lut_m [DEPTH];
  logic        mode_s = 1'b0, rdy_s = 1'b0;
  logic [2:0]  mask_s = 3'b111;
`ifdef SLI_TL_DETECT_EN
  logic [7:0]  tl_m;
`endif

  function automatic int m_fra(); return adv % NF; endfunction
  function automatic int m_frq(); return (adv / NF) % NQ; endfunction
  function automatic int m_addr(input int ln);
    return (m_fra() * PSTEP + ln * (1 << m_frq())) % DEPTH;
  endfunction

  function automatic logic [23:0] gen(input int l, input int x);
    logic [7:0] c0, c1, c2;
    c0 = 8'((x * 7 + l * 13) & 255);
    c1 = 8'((128 + x + l) & 255);
    c2 = 8'((192 ^ (x + l * 8)) & 255);
    return {c2, c1, c0};
  endfunction

  task automatic model_reset();
    adv = 0; line_m = 0; pend_m = 0; prev_vs = 0; prev_bl = 1; tl_arm_m = 0;
`ifdef SLI_TL_DETECT_EN
    tl_m = '0;
`endif
    vin.pix = '0; vin.hsync = 0; vin.vsync = 0; vin.blank = 1;
    cur = '{1'b1, 24'h0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
  endtask

  // One pixel clock of stimulus plus the expected output it implies
  task automatic cyc(input logic [23:0] p, input logic hs, input logic vs, input logic bl);
    bit ts;
    logic [23:0] ep;
    @(posedge clk); #1;
    mode = mode_s; ch_mask = mask_s; rdy = rdy_s;
    vin.pix = p; vin.hsync = hs; vin.vsync = vs; vin.blank = bl;
    ts = 1'b0;
    if (vs && !prev_vs) begin
      ts = pend_m; pend_m = 0;
      if (rdy_s) begin adv++; if (!mode_s) pend_m = 1; end
      line_m = 0; tl_arm_m = 1;
    end
    if (bl && !prev_bl) line_m++;
    if (!bl && prev_bl && tl_arm_m) begin
      tl_arm_m = 0;
`ifdef SLI_TL_DETECT_EN
      if (mode_s && p[7:0] != tl_m) begin tl_m = p[7:0]; pend_m = 1; end
`endif
    end
    ep = p;
    if (!bl && !mode_s)
      for (int c = 0; c < NCH; c++) if (mask_s[c]) ep[c*8 +: 8] = lut_m[m_addr(line_m)];
    cur = '{1'b1, ep, hs, vs, bl, m_fra(), m_frq(), ts};
    prev_vs = vs; prev_bl = bl;
  endtask

  task automatic frame(input int nl, input bit ov, input logic [7:0] tv);
    logic [23:0] p;
    repeat (3) cyc(24'h0, 0, 1, 1);
    repeat (2) cyc(24'h0, 0, 0, 1);
    for (int l = 0; l < nl; l++) begin
      for (int x = 0; x < 8; x++) begin
        p = gen(l, x);
        if (ov && l == 0 && x == 0) p[7:0] = tv;
        cyc(p, 0, 0, 0);
      end
      cyc(24'h0, 1, 0, 1);
      cyc(24'h0, 0, 0, 1);
      cyc(24'h0, 0, 0, 1);
    end
  endtask

  task automatic lut_wr(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    lut_we = 1; lut_addr = 10'(a); lut_data = d;
    if (a < DEPTH) lut_m[a] = d;
  endtask

  // ---------------- per-cycle compare ----------------
  int          rem, pulses = 0, run = 0, last_run = 0, ol = 0;
  bit          trig_p, ob_p, ovs_p;
  logic [23:0] line_pix [64];

  always @(negedge clk) begin
    if (!rstn) begin
      e1.v = 0; e2.v = 0; rem = 0; trig_p = 0; run = 0; ob_p = 1; ovs_p = 0;
    end else begin
      if (e2.v) begin
        if (e2.ts) rem = TC;
        chk("out_pix", vout.pix, e2.pix);
        chk("out_hsync", vout.hsync, e2.hs);
        chk("out_vsync", vout.vsync, e2.vs);
        chk("out_blank", vout.blank, e2.bl);
        chk("fra", fra, e2.fra);
        chk("frq", frq, e2.frq);
        chk("f_frm", f_frm, e2.fra == 0);
        chk("trig", trig, rem > 0);
        if (rem > 0) rem--;
      end
      if (trig && !trig_p) pulses++;
      if (trig) run++;
      else if (trig_p) begin last_run = run; run = 0; end
      trig_p = trig;
      if (vout.vsync && !ovs_p) ol = 0;
      if (!vout.blank && ob_p && ol < 64) begin line_pix[ol] = vout.pix; ol++; end
      ovs_p = vout.vsync; ob_p = vout.blank;
      e2 = e1; e1 = cur;
    end
  end

  // ---------------- directed sequence ----------------
  int p0;
  int exp_l0 [4];
  logic [23:0] px;

  initial begin
    exp_l0[0] = 90; exp_l0[1] = 180; exp_l0[2] = 14; exp_l0[3] = 104;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_blank", vout.blank, 1);
    chk("rst_vsync", vout.vsync, 0);
    chk("rst_hsync", vout.hsync, 0);
    chk("rst_pix", vout.pix, 0);
    chk("rst_trig", trig, 0);
    chk("rst_fra", fra, 0);
    chk("rst_frq", frq, 0);
    chk("rst_f_frm", f_frm, 1);
    @(posedge clk); #1 rstn = 1;

    for (int k = 0; k < DEPTH; k++) lut_wr(k, 8'(k % 256));
    lut_wr(720, 8'hEE);
    lut_wr(1000, 8'hEE);
    @(posedge clk); #1 lut_we = 0;

    // phase stepping
    mode_s = 0; mask_s = 3'b111; rdy_s = 1;
    for (int i = 1; i <= 4; i++) begin
      frame(4, 0, 0);
      chk($sformatf("fra_f%0d", i), fra, i);
      chk($sformatf("l0_f%0d", i), line_pix[0][15:8], exp_l0[i-1]);
    end
    for (int i = 5; i <= 16; i++) begin
      frame(4, 0, 0);
      if (i == 8) begin chk("frq_a8", frq, 1); chk("f_frm_a8", f_frm, 1); end
    end
    chk("frq_a16", frq, 2);
    chk("f_frm_a16", f_frm, 1);
    chk("line3_a16", line_pix[3], 24'h0C0C0C);

    mask_s = 3'b010;
    frame(4, 0, 0);
    chk("line3_mask010", line_pix[3], {8'hD8, 8'd102, 8'd39});
    mask_s = 3'b111;

    for (int i = 18; i <= 22; i++) frame(4, 0, 0);
    frame(24, 0, 0);
    chk("wrap_718", line_pix[22][15:8], 8'd206);
    chk("wrap_2", line_pix[23][15:8], 8'd2);
    frame(4, 0, 0);
    chk("frq_a24", frq, 0);
    chk("fra_a24", fra, 0);
    chk("f_frm_a24", f_frm, 1);

    // rdy hold
    mode_s = 1; frame(4, 0, 0);
    mode_s = 0; rdy_s = 0; p0 = pulses;
    repeat (3) frame(4, 0, 0);
    chk("hold_pulses", pulses - p0, 0);
    chk("hold_fra", fra, 1);
    chk("hold_frq", frq, 0);
    rdy_s = 1; frame(4, 0, 0);
    chk("resume_fra", fra, 2);
    chk("resume_nopulse", pulses - p0, 0);
    rdy_s = 0; frame(4, 0, 0);
    chk("resume_pulses", pulses - p0, 1);
    chk("pulse_width", last_run, TC);

    // retrigger: rises 10 cycles apart
    rdy_s = 1; frame(4, 0, 0);
    repeat (3) cyc(24'h0, 0, 1, 1);
    repeat (7) cyc(24'h0, 0, 0, 1);
    repeat (3) cyc(24'h0, 0, 1, 1);
    repeat (40) cyc(24'h0, 0, 0, 1);
    chk("retrig_width", last_run, 26);

    // top-left change detection in pass-through
    rdy_s = 0; frame(4, 0, 0);
    mode_s = 1; rdy_s = 1; p0 = pulses;
    frame(4, 1, 8'h40);
    frame(4, 1, 8'h41);
    frame(4, 1, 8'h41);
    repeat (3) cyc(24'h0, 0, 1, 1);
    repeat (30) cyc(24'h0, 0, 0, 1);
`ifdef SLI_TL_DETECT_EN
    chk("tl_pulses", pulses - p0, 2);
`else
    chk("tl_pulses", pulses - p0, 0);
`endif

    // reset in the middle of an active line
    mode_s = 0; mask_s = 3'b111; rdy_s = 1;
    repeat (3) cyc(24'h0, 0, 1, 1);
    repeat (2) cyc(24'h0, 0, 0, 1);
    for (int x = 0; x < 4; x++) begin px = gen(0, x); cyc(px, 0, 0, 0); end
    @(posedge clk); #1 rstn = 0;
    model_reset();
    #2;
    chk("mid_rst_blank", vout.blank, 1);
    chk("mid_rst_pix", vout.pix, 0);
    chk("mid_rst_trig", trig, 0);
    chk("mid_rst_fra", fra, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    p0 = pulses;
    repeat (5) cyc(24'h0, 0, 0, 1);
    frame(4, 0, 0);
    chk("post_rst_fra", fra, 1);
    chk("post_rst_l0", line_pix[0][15:8], 8'd90);
    chk("post_rst_notrig", pulses - p0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sli_pattern_gen.md
# sli_pattern_gen

Parametrised structured-light pattern generator for the HDMI pixel path: replaces active video with a sinusoidal fringe LUT value per line, stepping phase across frames and spatial frequency across phase sets. It advances under a camera-ready handshake and emits a fixed-width camera trigger. All video timing is sampled in the pixel clock domain; there are no sync-clocked processes. It sits between the HDMI receiver pixel output and the transmitter input, with the SD LUT loader driving its write port.

## Interface
- DATA_W, 8: bits per colour channel and per LUT entry.
- DEPTH, 720: number of LUT entries, one fringe period.
- N_FRAMES, 8: phase steps per frequency. DEPTH must be divisible by N_FRAMES.
- N_FREQ, 3: number of spatial frequencies. Requires 2^(N_FREQ-1) < DEPTH.
- NCH, 3: number of colour channels.
- TRIG_CYCLES, 524288: trigger pulse width in clk cycles, ≥1.
- clk  in  1  pixel clock.
- rstn  in  1  asynchronous active-low reset.
- lut_we  in  1  LUT write strobe.
- lut_addr  in  clog2(DEPTH)  write address. Writes to addresses ≥ DEPTH are ignored.
- lut_data  in  DATA_W  write data.
- mode  in  1  1 = pass-through, 0 = pattern.
- ch_mask  in  NCH  per-channel pattern enable in pattern mode.
- rdy  in  1  camera ready, sampled at vsync rise.
- in_pix  in  NCH*DATA_W  input pixel, channel 0 in the LSBs.
- in_hsync, in_vsync, in_blank  in  1 each  input timing.
- out_pix  out  NCH*DATA_W  output pixel.
- out_hsync, out_vsync, out_blank  out  1 each  delayed timing.
- trig  out  1  camera trigger.
- fra  out  clog2(N_FRAMES)  current phase index.
- frq  out  clog2(N_FREQ)  current frequency index.
- f_frm  out  1  high while fra == 0.

## Operation
- Input registration: inputs are registered once. Edges are detected by comparing the registered value with its previous value: vs_rise, bl_rise, bl_fall.
- Phase state:
  - start_phase: frame start LUT address.
  - acc: line address.
  - step = 1 << frq.
  - PSTEP = DEPTH/N_FRAMES.
- On vs_rise, processed in this order:
  1. If pend = 1, start the trigger and clear pend.
  2. If rdy = 1, advance:
     - fra increments.
     - start_phase = (start_phase + PSTEP) mod DEPTH.
     - At fra = N_FRAMES-1, fra goes to 0, start_phase goes to 0, and frq = (frq+1) mod N_FREQ.
     - Set pend.
  3. If rdy = 0, hold all indices.
  4. acc is loaded with the post-update start_phase.
- On bl_rise (end of an active line): acc = acc + step, minus DEPTH if the sum is ≥ DEPTH. The result is never ≥ DEPTH.
- Pixel selection:
  - In pattern mode, a channel with its ch_mask bit set during active video outputs LUT[acc].
  - In all other cases the channel outputs in_pix.
- LUT: synchronous read at acc. Writes take effect on the next clk edge and may occur at any time.
- Counters advance in both modes. pend is only set in pattern mode.
- Trigger:
  - A start loads cnt = TRIG_CYCLES and sets trig = 1.
  - cnt then decrements each cycle. trig falls when cnt reaches 0.
  - A start while trig is already high reloads cnt (retrigger).
- Reset mid-frame:
  - All state clears immediately.
  - The first vs_rise after rstn deasserts behaves as a normal frame start.
  - No trigger fires until pend is set.

## Timing
- Reset values: out_pix = 0, out_hsync = 0, out_vsync = 0, out_blank = 1, trig = 0, fra = 0, frq = 0, start_phase = 0, acc = 0, pend = 0, cnt = 0.
- Latency: out_pix and all out_* timing signals are exactly 2 clk cycles after the corresponding inputs, mutually aligned.
- fra, frq and pend update 1 cycle after the vs_rise detection cycle.
- trig rises in the same cycle as that update and is high for exactly TRIG_CYCLES cycles.
- acc updates 1 cycle after bl_rise and is stable before the next bl_fall (blanking ≥ 2 cycles is required).
- Line 0 of every frame uses start_phase. Line n uses (start_phase + n·step) mod DEPTH.

## Configuration
- SLI_TL_DETECT_EN defined: in pass-through mode, on bl_fall of the first active line after vs_rise, channel 0 of in_pix is compared with the stored top-left value.
  - If it differs, the stored value is updated and pend is set, so a trigger fires at the next vs_rise.
  - The stored top-left value resets to 0.
- SLI_TL_DETECT_EN undefined: pass-through mode never sets pend and never triggers. The comparison logic is absent.

## Test plan
- Reset, then stream 4 frames with rdy = 1, DEPTH = 720, N_FRAMES = 8 -> fra = 1, 2, 3, 4 and the frame-start LUT address = 90, 180, 270, 360. out_blank = 1 during reset.
- LUT[k] = k mod 256, frq = 2, start_phase = 0 -> active line 3 outputs 12 on all masked channels. With ch_mask = 3'b010, channels 0 and 2 pass in_pix.
- rdy = 0 for 3 vsyncs -> fra, frq and the pattern are held and trig never fires. After rdy returns to 1: one advance, then exactly one trig pulse of TRIG_CYCLES = 16 cycles at the following vsync.
- Run 24 frames with rdy = 1 -> frq sequence 0, 1, 2, 0 at fra wrap, and f_frm high on frames 0, 8, 16, 24. Wrap: step = 4, acc = 718 -> next line = 2.
- Two vsync rises 10 cycles apart with pend set, TRIG_CYCLES = 16 -> trig high continuously for 26 cycles.
- SLI_TL_DETECT_EN, mode = 1: top-left red 0x40 then 0x41 -> one trig after the second frame. Repeated 0x41 -> no trig. Macro undefined -> never a trig.
